// File: rtl/button_conditioner.sv
// Three-key conditioner: 2-flop sync, per-key debounce, single-cycle press pulses.
// Define BTN_AUTOREPEAT_EN to compile in auto-repeat on the move key.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_n,
  input  logic       move_n,
  input  logic       select_n,
  output logic       start_p,
  output logic       move_p,
  output logic       select_p,
  output logic [2:0] held
);
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Bit order everywhere is {start, move, select}.
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_stable;
  logic [2:0]    r_armed;
  logic [2:0]    r_pulse;
  logic [1:0]    r_ok;
  logic [CW-1:0] r_cnt [3];
  logic [2:0]    w_s2;
  logic [2:0]    w_accept;
  logic [2:0]    w_press;
  logic          w_rep_fire;

  assign w_s2 = ~r_sync2;

  always_comb begin
    w_accept = '0;
    for (int i = 0; i < 3; i++) begin
      w_accept[i] = (r_cnt[i] == CNT_LAST) && (w_s2[i] != r_stable[i]);
    end
  end

  assign w_press = w_accept & w_s2 & r_armed;

  // r_ok masks the forced "released" sync values right after reset, so a key
  // held through reset never arms until a genuine release has been sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_ok     <= '0;
      r_stable <= '0;
      r_armed  <= '0;
      r_pulse  <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= {start_n, move_n, select_n};
      r_sync2 <= r_sync1;
      r_ok    <= {r_ok[0], 1'b1};
      r_pulse <= w_press | {1'b0, w_rep_fire, 1'b0};
      for (int i = 0; i < 3; i++) begin
        if ((w_s2[i] == r_stable[i]) || w_accept[i]) r_cnt[i] <= '0;
        else                                         r_cnt[i] <= r_cnt[i] + CW'(1);
        if (w_accept[i]) r_stable[i] <= w_s2[i];
        if (w_press[i])                                   r_armed[i] <= 1'b0;
        else if (r_ok[1] && !r_stable[i] && !w_s2[i])     r_armed[i] <= 1'b1;
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int            RMAX      = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int            RW        = $clog2(RMAX + 1);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] r_rep_cnt;
  logic          r_rep_act;
  logic          w_move_release;

  assign w_move_release = w_accept[1] & ~w_s2[1];
  assign w_rep_fire     = r_rep_act && r_stable[1] && !w_move_release && (r_rep_cnt == '0);

  // Down-counter reloaded at the press pulse; fires on reaching zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep_act <= 1'b0;
      r_rep_cnt <= '0;
    end else if (w_press[1]) begin
      r_rep_act <= 1'b1;
      r_rep_cnt <= REP_FIRST;
    end else if (!r_stable[1] || w_move_release) begin
      r_rep_act <= 1'b0;
      r_rep_cnt <= '0;
    end else if (r_rep_act) begin
      r_rep_cnt <= (r_rep_cnt == '0) ? REP_NEXT : r_rep_cnt - RW'(1);
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign w_rep_fire        = 1'b0;
`endif

  assign start_p  = r_pulse[2];
  assign move_p   = r_pulse[1];
  assign select_p = r_pulse[0];
  assign held     = r_stable;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8).
module tb_button_conditioner;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_n = 1'b1;
  logic       move_n = 1'b1;
  logic       select_n = 1'b1;
  logic       start_p;
  logic       move_p;
  logic       select_p;
  logic [2:0] held;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start_n (start_n),
    .move_n  (move_n),
    .select_n(select_n),
    .start_p (start_p),
    .move_p  (move_p),
    .select_p(select_p),
    .held    (held)
  );

  // One row per clock: keys driven before the edge, outputs expected after it.
  typedef struct {
    logic [2:0] keys_n;
    logic [2:0] pulses;
    logic [2:0] held;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic [2:0] k, input logic [2:0] p, input logic [2:0] h);
    vec_t v;
    v.keys_n = k;
    v.pulses = p;
    v.held   = h;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] k);
    {start_n, move_n, select_n} = k;
  endtask

  function automatic logic [2:0] pulses();
    return {start_p, move_p, select_p};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int at;
    int other;
    int seen[$];
    int exp_at[$];

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset pulses", pulses(), 3'b000);
    check("reset held", held, 3'b000);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("idle pulses", pulses(), 3'b000);
    check("idle held", held, 3'b000);

    // Clean move press and release
    add(5, 3'b101, 3'b000, 3'b000);
    add(1, 3'b101, 3'b010, 3'b010);
    add(4, 3'b101, 3'b000, 3'b010);
    add(5, 3'b111, 3'b000, 3'b010);
    add(5, 3'b111, 3'b000, 3'b000);
    // Bouncing select: low3 high1 low2 high1 then steady low
    add(3, 3'b110, 3'b000, 3'b000);
    add(1, 3'b111, 3'b000, 3'b000);
    add(2, 3'b110, 3'b000, 3'b000);
    add(1, 3'b111, 3'b000, 3'b000);
    add(5, 3'b110, 3'b000, 3'b000);
    add(1, 3'b110, 3'b001, 3'b001);
    add(4, 3'b110, 3'b000, 3'b001);
    add(5, 3'b111, 3'b000, 3'b001);
    add(5, 3'b111, 3'b000, 3'b000);
    // Simultaneous start + select
    add(5, 3'b010, 3'b000, 3'b000);
    add(1, 3'b010, 3'b101, 3'b101);
    add(4, 3'b010, 3'b000, 3'b101);
    add(5, 3'b111, 3'b000, 3'b101);
    add(5, 3'b111, 3'b000, 3'b000);

    for (int r = 0; r < vecs.size(); r++) begin
      drive(vecs[r].keys_n);
      @(negedge clk);
      check($sformatf("vec%0d pulses", r), pulses(), vecs[r].pulses);
      check($sformatf("vec%0d held", r), held, vecs[r].held);
    end

    // Start held through reset: no pulse until released and pressed again
    drive(3'b011);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("lockout in reset", {pulses(), held}, 6'b0);
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (start_p) n++;
    end
    check("lockout start_p count", n, 0);
    check("lockout held", held, 3'b100);
    drive(3'b111);
    repeat (6) @(negedge clk);
    drive(3'b011);
    n = 0;
    at = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (start_p) begin
        n++;
        at = k;
      end
    end
    check("relock start_p count", n, 1);
    check("relock start_p edge", at, DB + 1);
    drive(3'b111);
    repeat (10) @(negedge clk);

    // Reset in the middle of a select debounce (counter==2)
    drive(3'b110);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    drive(3'b111);
    @(negedge clk);
    check("mid-debounce reset pulses", pulses(), 3'b000);
    check("mid-debounce reset held", held, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset cycle pulses", pulses(), 3'b000);
    repeat (3) @(negedge clk);
    drive(3'b110);
    n = 0;
    at = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (select_p) begin
        n++;
        at = k;
      end
    end
    check("restart select_p count", n, 1);
    check("restart select_p edge", at, DB + 1);
    drive(3'b111);
    repeat (10) @(negedge clk);

    // Move held 50 cycles: auto-repeat when enabled, single pulse otherwise
`ifdef BTN_AUTOREPEAT_EN
    exp_at = '{5, 25, 33, 41, 49};
`else
    exp_at = '{5};
`endif
    other = 0;
    for (int k = 0; k < 80; k++) begin
      drive((k < 50) ? 3'b101 : 3'b111);
      @(negedge clk);
      if (move_p) seen.push_back(k);
      if (start_p || select_p) other++;
    end
    check("repeat pulse count", seen.size(), exp_at.size());
    for (int i = 0; i < exp_at.size() && i < seen.size(); i++) begin
      check($sformatf("repeat pulse %0d edge", i), seen[i], exp_at[i]);
    end
    check("repeat other pulses", other, 0);
    check("repeat final held", held, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the consecutive stable cycles needed to accept a level change (10 ms at 50 MHz, minimum 2).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 25000000, giving the cycles from a move press pulse to the first repeat pulse.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 10000000, giving the cycles between successive move repeat pulses.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, which is synchronous and active-high.
REQ-006 The block SHALL have ports start_n, move_n and select_n, each input, 1 bit: raw asynchronous board keys, active-low.
REQ-007 The block SHALL have ports start_p, move_p and select_p, each output, 1 bit: single-cycle active-high press pulses for the game controller.
REQ-008 The block SHALL have port held, output, 3 bits: the debounced active-high levels {start, move, select}.

Function
REQ-009 Each key SHALL pass through a 2-flop synchronizer and then be inverted to active-high (s2); no combinational path SHALL exist from a raw key to any output.
REQ-010 Each key SHALL have its own debounce counter (width clog2(DEBOUNCE_CYCLES)) and a stable bit.
- s2 == stable: counter cleared.
- otherwise: counter increments.
- counter == DEBOUNCE_CYCLES-1 with s2 != stable: stable <= s2 and counter cleared on that edge.
REQ-011 Any bounce shorter than DEBOUNCE_CYCLES consecutive cycles SHALL leave stable, held and the pulses unchanged.
REQ-012 Each key SHALL have an armed bit: it is set on any edge where stable == 0 and s2 == 0, and cleared when a press is accepted.
REQ-013 The x_p output SHALL be registered high for exactly one cycle on the edge where stable goes 0->1 while armed == 1; a release SHALL produce no pulse.
REQ-014 Latency SHALL be fixed: counting the edge that first samples a key low as edge 0, x_p and held[x] are high after edge DEBOUNCE_CYCLES+1.
REQ-015 The three keys SHALL be fully independent: simultaneous presses produce simultaneous pulses with no priority or masking.
REQ-016 A key held continuously SHALL produce exactly one pulse, unless the REQ-022 repeat behaviour applies.
REQ-017 held[x] SHALL equal stable[x].

Reset
REQ-018 On rst, the block SHALL set s1/s2 to the released state, and clear counters, stable, armed, the repeat state, all x_p and held.
REQ-019 A key held across reset deassertion SHALL produce no pulse until it has been debounced released and then pressed again; held still reflects it after DEBOUNCE_CYCLES+1 edges.
REQ-020 rst asserted mid-debounce or mid-repeat SHALL abort that activity, and no pulse SHALL be issued in the cycle following reset.

Configuration
REQ-021 The macro BTN_AUTOREPEAT_EN SHALL compile the move auto-repeat logic in or out.
REQ-022 With BTN_AUTOREPEAT_EN defined, the move key SHALL auto-repeat.
- A repeat counter starts at the move press pulse.
- While held[1] stays 1, move_p pulses one cycle at REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles.
- held[1] falling clears the counter immediately.
- start and select never repeat.
REQ-023 Without BTN_AUTOREPEAT_EN, the repeat counter SHALL be absent and move SHALL behave exactly like start and select.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-024 Clean press: with move_n low from sampling edge 0 and held, move_p SHALL be high only after edge 5, held[1] SHALL go 1 after edge 5, and no other pulses SHALL occur.
REQ-025 Bounce: with select_n toggling low 3 cycles, high 1, low 2, high 1, then low steady, select_p SHALL fire exactly once, 5 edges after the start of the final steady-low run.
REQ-026 Simultaneous: with start_n and select_n both falling on the same edge, start_p and select_p SHALL pulse on the same cycle, both exactly once.
REQ-027 Reset lockout: with start_n held low through rst and for 30 cycles after, start_p SHALL stay 0 and held[2] SHALL be 1. After a release of 6 cycles then a press, one start_p SHALL be issued.
REQ-028 Auto-repeat (macro on): holding move_n low for 50 cycles SHALL give move_p at press edge P, then P+20, P+28, P+36, P+44, and no pulses after release. With the macro off, the same stimulus SHALL give only the pulse at P.
REQ-029 Mid-debounce reset: rst for 1 cycle at counter==2 SHALL give no pulse, and the counter SHALL restart from 0 (a pulse follows DEBOUNCE_CYCLES+1 edges after re-sampling, per REQ-014).
